id_stage: RTL

Instruction-decode stage of the 5-stage MIPS pipeline, directly downstream of the fetch stage. It holds the IF/ID latch, the 32×32 register file and the main control decoder. It also runs load-use hazard detection, which drives the fetch stage's stall input, and produces a registered ID/EX bundle for the execute stage.

---
 rtl/id_stage_pkg.sv | 31 +++
 rtl/id_stage_register_file.sv | 67 ++++++
 rtl/id_stage.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/id_stage_pkg.sv
// Shared decode definitions for the MIPS ID stage: opcodes, ALU-op encodings
// and the control bundle carried from decode into ID/EX.
package id_stage_pkg;

    localparam int REG_AW = 5;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_HALT  = 6'b111111;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    typedef struct packed {
        logic       reg_dst;
        logic       alu_src;
        logic       branch;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       reg_write;
        logic [1:0] alu_op;
    } ctrl_t;

    localparam ctrl_t CTRL_NONE = ctrl_t'(9'd0);

endpackage

// File: rtl/id_stage_register_file.sv
// 2-read / 1-write register file with r0 hardwired to zero and same-cycle
// write-through from the writeback port.
module register_file
    import id_stage_pkg::*;
#(
    parameter int NBITS = 32,
    parameter int NREGS = 32
) (
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic                i_enable,
    input  logic                i_we,
    input  logic [REG_AW-1:0]   i_waddr,
    input  logic [NBITS-1:0]    i_wdata,
    input  logic [REG_AW-1:0]   i_raddr1,
    input  logic [REG_AW-1:0]   i_raddr2,
    output logic [NBITS-1:0]    o_rdata1,
    output logic [NBITS-1:0]    o_rdata2
);

    logic [NBITS-1:0] regs_q [NREGS];
    logic [NBITS-1:0] regs_d [NREGS];

    // Next register contents: single write port, r0 never written
    always_comb begin
        regs_d = regs_q;
        if (i_enable && i_we && (i_waddr != {REG_AW{1'b0}})) begin
            regs_d[i_waddr] = i_wdata;
        end else begin
            regs_d = regs_q;
        end
    end

    // Register storage
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= {NBITS{1'b0}};
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    // Read port 1; the bypass lets a writeback feed decode in the same cycle
    always_comb begin
        if (i_raddr1 == {REG_AW{1'b0}}) begin
            o_rdata1 = {NBITS{1'b0}};
        end else if (i_we && (i_waddr == i_raddr1)) begin
            o_rdata1 = i_wdata;
        end else begin
            o_rdata1 = regs_q[i_raddr1];
        end
    end

    // Read port 2
    always_comb begin
        if (i_raddr2 == {REG_AW{1'b0}}) begin
            o_rdata2 = {NBITS{1'b0}};
        end else if (i_we && (i_waddr == i_raddr2)) begin
            o_rdata2 = i_wdata;
        end else begin
            o_rdata2 = regs_q[i_raddr2];
        end
    end

endmodule

// File: rtl/id_stage.sv
// MIPS instruction-decode stage: IF/ID latch, register file, control decode,
// load-use hazard detection and the registered ID/EX bundle.
module id_stage
    import id_stage_pkg::*;
#(
    parameter int NBITS = 32,
    parameter int NREGS = 32
) (
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic                i_enable,
    input  logic [NBITS-1:0]    i_instruction,
    input  logic [NBITS-1:0]    i_PC_4,
    input  logic                i_flush,
    input  logic                i_wb_regWrite,
    input  logic [4:0]          i_wb_addr,
    input  logic [NBITS-1:0]    i_wb_data,
    input  logic                i_ex_memRead,
    input  logic [4:0]          i_ex_rt,
    output logic                o_stall,
    output logic [NBITS-1:0]    o_PC_4,
    output logic [NBITS-1:0]    o_readData1,
    output logic [NBITS-1:0]    o_readData2,
    output logic [NBITS-1:0]    o_immExt,
    output logic [4:0]          o_rs,
    output logic [4:0]          o_rt,
    output logic [4:0]          o_rd,
    output logic                o_regDst,
    output logic                o_aluSrc,
    output logic                o_branch,
    output logic                o_memRead,
    output logic                o_memWrite,
    output logic                o_memToReg,
    output logic                o_regWrite,
    output logic [1:0]          o_aluOp,
    output logic                o_halt,
    output logic                o_valid
);

    logic [NBITS-1:0] ifid_instr_q, ifid_instr_d, ifid_pc4_q, ifid_pc4_d;
    logic             ifid_valid_q, ifid_valid_d;

    logic [5:0]       opcode_s;
    logic [4:0]       rs_s, rt_s, rd_s;
    logic [NBITS-1:0] rdata1_s, rdata2_s, imm_ext_s;
    ctrl_t            dec_ctrl_s;
    logic             dec_halt_s, stall_s, issue_s;

    logic [NBITS-1:0] pc4_q, pc4_d, rd1_q, rd1_d, rd2_q, rd2_d, imm_q, imm_d;
    logic [4:0]       rs_q, rs_d, rt_q, rt_d, rd_q, rd_d;
    ctrl_t            ctrl_q, ctrl_d;
    logic             valid_q, valid_d, halt_q, halt_d;

    assign opcode_s  = ifid_instr_q[31:26];
    assign rs_s      = ifid_instr_q[25:21];
    assign rt_s      = ifid_instr_q[20:16];
    assign rd_s      = ifid_instr_q[15:11];
    assign imm_ext_s = {{(NBITS-16){ifid_instr_q[15]}}, ifid_instr_q[15:0]};

    register_file #(.NBITS(NBITS), .NREGS(NREGS)) u_regfile (
        .i_clk    (i_clk),
        .i_reset  (i_reset),
        .i_enable (i_enable),
        .i_we     (i_wb_regWrite),
        .i_waddr  (i_wb_addr),
        .i_wdata  (i_wb_data),
        .i_raddr1 (rs_s),
        .i_raddr2 (rt_s),
        .o_rdata1 (rdata1_s),
        .o_rdata2 (rdata2_s)
    );

    // Main control decoder
    always_comb begin
        dec_ctrl_s = CTRL_NONE;
        dec_halt_s = 1'b0;
        case (opcode_s)
            OP_RTYPE: begin
                dec_ctrl_s.reg_dst   = 1'b1;
                dec_ctrl_s.reg_write = 1'b1;
                dec_ctrl_s.alu_op    = ALUOP_FUNCT;
            end
            OP_LW: begin
                dec_ctrl_s.alu_src    = 1'b1;
                dec_ctrl_s.mem_to_reg = 1'b1;
                dec_ctrl_s.reg_write  = 1'b1;
                dec_ctrl_s.mem_read   = 1'b1;
                dec_ctrl_s.alu_op     = ALUOP_ADD;
            end
            OP_SW: begin
                dec_ctrl_s.alu_src   = 1'b1;
                dec_ctrl_s.mem_write = 1'b1;
                dec_ctrl_s.alu_op    = ALUOP_ADD;
            end
            OP_BEQ: begin
                dec_ctrl_s.branch = 1'b1;
                dec_ctrl_s.alu_op = ALUOP_SUB;
            end
            OP_ADDI: begin
                dec_ctrl_s.alu_src   = 1'b1;
                dec_ctrl_s.reg_write = 1'b1;
                dec_ctrl_s.alu_op    = ALUOP_ADD;
            end
            OP_HALT:  dec_halt_s = 1'b1;
            default:  dec_ctrl_s = CTRL_NONE;
        endcase
    end

    assign stall_s = ifid_valid_q && i_ex_memRead && (i_ex_rt != 5'd0)
                     && ((i_ex_rt == rs_s) || (i_ex_rt == rt_s));
    assign issue_s = ifid_valid_q && !i_flush && !stall_s && !halt_q;
    assign o_stall = stall_s;

    // IF/ID latch next state; flush outranks stall
    always_comb begin
        ifid_instr_d = ifid_instr_q;
        ifid_pc4_d   = ifid_pc4_q;
        ifid_valid_d = ifid_valid_q;
        if (!i_enable) begin
            ifid_valid_d = ifid_valid_q;
        end else if (i_flush) begin
            ifid_instr_d = {NBITS{1'b0}};
            ifid_valid_d = 1'b0;
        end else if (stall_s) begin
            ifid_valid_d = ifid_valid_q;
        end else begin
            ifid_instr_d = i_instruction;
            ifid_pc4_d   = i_PC_4;
            ifid_valid_d = 1'b1;
        end
    end

    // ID/EX next state: data always advances, control becomes a bubble unless issuing
    always_comb begin
        pc4_d   = pc4_q;
        rd1_d   = rd1_q;
        rd2_d   = rd2_q;
        imm_d   = imm_q;
        rs_d    = rs_q;
        rt_d    = rt_q;
        rd_d    = rd_q;
        ctrl_d  = ctrl_q;
        valid_d = valid_q;
        halt_d  = halt_q;
        if (i_enable) begin
            pc4_d = ifid_pc4_q;
            rd1_d = rdata1_s;
            rd2_d = rdata2_s;
            imm_d = imm_ext_s;
            rs_d  = rs_s;
            rt_d  = rt_s;
            rd_d  = rd_s;
            if (issue_s) begin
                ctrl_d  = dec_ctrl_s;
                valid_d = 1'b1;
                halt_d  = halt_q | dec_halt_s;
            end else begin
                ctrl_d  = CTRL_NONE;
                valid_d = 1'b0;
                halt_d  = halt_q;
            end
        end else begin
            halt_d = halt_q;
        end
    end

    // Pipeline state registers
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            ifid_instr_q <= {NBITS{1'b0}};
            ifid_pc4_q   <= {NBITS{1'b0}};
            ifid_valid_q <= 1'b0;
            pc4_q        <= {NBITS{1'b0}};
            rd1_q        <= {NBITS{1'b0}};
            rd2_q        <= {NBITS{1'b0}};
            imm_q        <= {NBITS{1'b0}};
            rs_q         <= 5'd0;
            rt_q         <= 5'd0;
            rd_q         <= 5'd0;
            ctrl_q       <= CTRL_NONE;
            valid_q      <= 1'b0;
            halt_q       <= 1'b0;
        end else begin
            ifid_instr_q <= ifid_instr_d;
            ifid_pc4_q   <= ifid_pc4_d;
            ifid_valid_q <= ifid_valid_d;
            pc4_q        <= pc4_d;
            rd1_q        <= rd1_d;
            rd2_q        <= rd2_d;
            imm_q        <= imm_d;
            rs_q         <= rs_d;
            rt_q         <= rt_d;
            rd_q         <= rd_d;
            ctrl_q       <= ctrl_d;
            valid_q      <= valid_d;
            halt_q       <= halt_d;
        end
    end

    assign o_PC_4      = pc4_q;
    assign o_readData1 = rd1_q;
    assign o_readData2 = rd2_q;
    assign o_immExt    = imm_q;
    assign o_rs        = rs_q;
    assign o_rt        = rt_q;
    assign o_rd        = rd_q;
    assign o_regDst    = ctrl_q.reg_dst;
    assign o_aluSrc    = ctrl_q.alu_src;
    assign o_branch    = ctrl_q.branch;
    assign o_memRead   = ctrl_q.mem_read;
    assign o_memWrite  = ctrl_q.mem_write;
    assign o_memToReg  = ctrl_q.mem_to_reg;
    assign o_regWrite  = ctrl_q.reg_write;
    assign o_aluOp     = ctrl_q.alu_op;
    assign o_halt      = halt_q;
    assign o_valid     = valid_q;

endmodule
